ifu_fetch: RTL

Instruction fetch front end that consumes the next-PC / read-request stream from the PC register stage and issues one icache request at a time. It returns each fetched instruction to decode through a 2-entry buffer. Back toward the PC stage it drives the stall and the compressed-instruction size that decide when and by how much the PC advances. One outstanding icache access; redirects from execute or trap discard in-flight data.

---
 rtl/ifu_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch front end with one outstanding icache access
//            and a 2-entry decode buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
   parameter int ADDR_W     = 64,
   parameter int INST_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_next_i,
   input  logic              read_req_i,
   input  logic              redirect_i,
   output logic              stall_o,
   output logic              is_compressed_o,
   output logic              ic_req_valid_o,
   input  logic              ic_req_ready_i,
   output logic [ADDR_W-1:0] ic_req_addr_o,
   input  logic              ic_resp_valid_i,
   input  logic [INST_W-1:0] ic_resp_data_i,
   input  logic              ic_resp_err_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_compressed_o,
   output logic              inst_fault_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] BUF_FULL = 2'(FIFO_DEPTH);

   state_t            state_q, state_d;
   logic              drop_q, drop_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [INST_W-1:0] data_q [2];
   logic [INST_W-1:0] data_d [2];
   logic [ADDR_W-1:0] pc_q   [2];
   logic [ADDR_W-1:0] pc_d   [2];
   logic [1:0]        comp_q, comp_d;
   logic [1:0]        fault_q, fault_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   logic can_issue;
   logic accepted_resp;
   logic resp_comp;
   logic pop;

   // Issue never depends on the icache response path.
   assign can_issue     = read_req_i & ~redirect_i & (count_q != BUF_FULL);
   assign accepted_resp = (state_q == ST_WAIT) & ic_resp_valid_i & ~drop_q & ~redirect_i;
   assign resp_comp     = (ic_resp_data_i[1:0] != 2'b11) & ~ic_resp_err_i;
   assign pop           = inst_valid_o & inst_ready_i & ~redirect_i;

   assign ic_req_valid_o    = (state_q == ST_REQ) | ((state_q == ST_IDLE) & can_issue);
   assign ic_req_addr_o     = (state_q == ST_IDLE) ? pc_next_i : addr_q;
   assign stall_o           = ~(accepted_resp | redirect_i);
   assign is_compressed_o   = accepted_resp & resp_comp;

   assign inst_valid_o      = (count_q != 2'd0);
   assign inst_o            = data_q[rd_ptr_q];
   assign inst_pc_o         = pc_q[rd_ptr_q];
   assign inst_compressed_o = comp_q[rd_ptr_q];
   assign inst_fault_o      = fault_q[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (can_issue) begin
               addr_d  = pc_next_i;
               state_d = ic_req_ready_i ? ST_WAIT : ST_REQ;
            end
         end
         ST_REQ: begin
            // The request stays up across a redirect; its response is dropped.
            if (redirect_i) drop_d = 1'b1;
            if (ic_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (ic_resp_valid_i) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
            end else if (redirect_i) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d   = data_q;
      pc_d     = pc_q;
      comp_d   = comp_q;
      fault_d  = fault_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (accepted_resp) begin
            data_d[wr_ptr_q]  = ic_resp_err_i ? '0 : ic_resp_data_i;
            pc_d[wr_ptr_q]    = addr_q;
            comp_d[wr_ptr_q]  = resp_comp;
            fault_d[wr_ptr_q] = ic_resp_err_i;
            wr_ptr_d          = ~wr_ptr_q;
         end
         if (pop) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, accepted_resp} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         drop_q    <= 1'b0;
         addr_q    <= '0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         pc_q[0]   <= '0;
         pc_q[1]   <= '0;
         comp_q    <= 2'b00;
         fault_q   <= 2'b00;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pc_q      <= pc_d;
         comp_q    <= comp_d;
         fault_q   <= fault_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

endmodule

`default_nettype wire
